// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron core and its serial parameter loader.
package lif_pkg;

    localparam int LIF_PARAM_WIDTH = 8;
    localparam int LIF_NUM_PARAMS  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_ACK = 2'd2
    } loader_state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lif_param_shifter.sv
// One parameter word, shifted out MSB-first; flags when the last bit of the word is current.
module lif_param_shifter
    import lif_pkg::*;
#(
    parameter int WIDTH = LIF_PARAM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_word,
    output logic             msb_d,
    output logic             last_bit
);

    localparam int IW = min1_clog2(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]    idx_q, idx_d;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load) begin
            shreg_d = load_word;
            idx_d   = '0;
        end else if (shift) begin
            shreg_d = shreg_q << 1;
            idx_d   = idx_q + IW'(1);
        end
    end

    // The next-state MSB lets the parent register the serial line on the same edge.
    assign msb_d    = shreg_d[WIDTH-1];
    assign last_bit = (idx_q == IW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/lif_param_loader.sv
// Host-side programmer for the neuron's load_mode/serial_data port: register file,
// frame sequencer and acknowledge/timeout handling.
module lif_param_loader
    import lif_pkg::*;
#(
    parameter int NUM_PARAMS = LIF_NUM_PARAMS,
    parameter int WIDTH      = LIF_PARAM_WIDTH,
    parameter int TIMEOUT    = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                bit_en,
    input  logic                                wr_en,
    input  logic [min1_clog2(NUM_PARAMS)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]                    wr_data,
    input  logic                                start,
    input  logic                                abort,
    input  logic                                params_ready,
    output logic                                load_mode,
    output logic                                serial_data,
    output logic                                busy,
    output logic                                done,
    output logic                                timeout_err
);

    localparam int AW    = min1_clog2(NUM_PARAMS);
    localparam int TOTAL = NUM_PARAMS * WIDTH;
    localparam int BW    = $clog2(TOTAL + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    loader_state_t    state_q, state_d;
    logic             start_q, start_d;
    logic             ack_q, ack_d;
    logic [AW-1:0]    word_idx_q, word_idx_d, next_idx;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             load_mode_q, load_mode_d;
    logic             serial_data_q, serial_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_err_q, timeout_err_d;
    logic [WIDTH-1:0] regs_q [NUM_PARAMS];
    logic [WIDTH-1:0] regs_d [NUM_PARAMS];

    logic             wr_fire, last_step;
    logic             sh_load, sh_shift, sh_msb_d, sh_last;
    logic [WIDTH-1:0] sh_word;

    // A sampled start is held one cycle before the frame opens, so block writes then.
    assign wr_fire  = wr_en && (state_q == IDLE) && !start_q && (32'(wr_addr) < NUM_PARAMS);
    assign next_idx = word_idx_q + AW'(1);

    for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_regfile
        assign regs_d[gi] = (wr_fire && (wr_addr == AW'(gi))) ? wr_data : regs_q[gi];
    end

    always_comb begin
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_word   = regs_q[0];
        last_step = 1'b0;
        if ((state_q == IDLE) && start_q) begin
            sh_load = 1'b1;
        end else if ((state_q == SHIFT) && !abort && bit_en) begin
            last_step = (bit_cnt_q == BW'(TOTAL - 1));
            if (!last_step) begin
                if (sh_last) begin
                    sh_load = 1'b1;
                    sh_word = regs_q[next_idx];
                end else begin
                    sh_shift = 1'b1;
                end
            end
        end
    end

    lif_param_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (sh_load),
        .shift     (sh_shift),
        .load_word (sh_word),
        .msb_d     (sh_msb_d),
        .last_bit  (sh_last)
    );

    always_comb begin
        state_d       = state_q;
        start_d       = 1'b0;
        ack_d         = 1'b0;
        word_idx_d    = word_idx_q;
        bit_cnt_d     = bit_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        load_mode_d   = load_mode_q;
        serial_data_d = serial_data_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            IDLE: begin
                start_d = start && !abort && !start_q;
                if (start_q) begin
                    state_d       = SHIFT;
                    word_idx_d    = '0;
                    bit_cnt_d     = '0;
                    load_mode_d   = 1'b1;
                    serial_data_d = sh_msb_d;
                    busy_d        = 1'b1;
                    timeout_err_d = 1'b0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d       = IDLE;
                    load_mode_d   = 1'b0;
                    serial_data_d = 1'b0;
                    busy_d        = 1'b0;
                end else if (bit_en) begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (last_step) begin
                        state_d       = WAIT_ACK;
                        wait_cnt_d    = '0;
                        load_mode_d   = 1'b0;
                        serial_data_d = 1'b0;
                    end else begin
                        serial_data_d = sh_msb_d;
                        if (sh_last) word_idx_d = next_idx;
                    end
                end
            end
            WAIT_ACK: begin
                // An ack seen on the timeout cycle wins; done follows one cycle later.
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (ack_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                    if (params_ready) begin
                        ack_d = 1'b1;
                    end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                        state_d       = IDLE;
                        busy_d        = 1'b0;
                        timeout_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d       = IDLE;
                load_mode_d   = 1'b0;
                serial_data_d = 1'b0;
                busy_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            ack_q         <= 1'b0;
            word_idx_q    <= '0;
            bit_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            load_mode_q   <= 1'b0;
            serial_data_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < NUM_PARAMS; i++) regs_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            ack_q         <= ack_d;
            word_idx_q    <= word_idx_d;
            bit_cnt_q     <= bit_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            load_mode_q   <= load_mode_d;
            serial_data_q <= serial_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            regs_q        <= regs_d;
        end
    end

    assign load_mode   = load_mode_q;
    assign serial_data = serial_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule
